// File: rtl/sequenciador_pkg.sv
// Shared state encodings and default timing constants for the display
// sequencer and the game control unit.
package sequenciador_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int unsigned T_ACESO_LENTO_PADRAO  = 500;
  localparam int unsigned T_ACESO_RAPIDO_PADRAO = 250;
  localparam int unsigned T_INTERVALO_PADRAO    = 250;

  // Terminal count for a phase lasting n cycles (count runs 0..n-1).
  function automatic logic [15:0] limite_ciclos(input int unsigned n);
    return (n == 0) ? '0 : 16'(n - 1);
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// 16-bit phase timer: synchronous clear over enable, with a terminal
// compare against an externally selected limit.
module contador_tempo (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limite,
  output logic [15:0] contagem,
  output logic        fim
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contagem <= '0;
    else if (clear)  contagem <= '0;
    else if (enable) contagem <= contagem + 16'd1;
  end

  assign fim = (contagem == limite);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays back a stored sequence on one-hot LEDs: each element is fetched,
// shown for the selected on-time, then blanked for a fixed gap.
module sequenciador_exibicao
  import sequenciador_pkg::*;
#(
  parameter int unsigned T_ACESO_LENTO  = T_ACESO_LENTO_PADRAO,
  parameter int unsigned T_ACESO_RAPIDO = T_ACESO_RAPIDO_PADRAO,
  parameter int unsigned T_INTERVALO    = T_INTERVALO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic       nivel_tempo,
  input  logic       pausa,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       toca,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam logic [15:0] LIM_LENTO     = limite_ciclos(T_ACESO_LENTO);
  localparam logic [15:0] LIM_RAPIDO    = limite_ciclos(T_ACESO_RAPIDO);
  localparam logic [15:0] LIM_INTERVALO = limite_ciclos(T_INTERVALO);

  estado_t     estado, proximo;
  logic [3:0]  rodada_reg;
  logic        nivel_reg;
  logic [3:0]  exibicao;
  logic [15:0] limite;
  logic [15:0] contagem;
  logic        limpa, conta, fim_tempo;

  contador_tempo u_contador_tempo (
    .clock    (clock),
    .reset    (reset),
    .clear    (limpa),
    .enable   (conta),
    .limite   (limite),
    .contagem (contagem),
    .fim      (fim_tempo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Pausa only gates the two timed phases; all other states are single-cycle.
  always_comb begin
    proximo = estado;
    limpa   = 1'b0;
    conta   = 1'b0;
    limite  = '0;
    case (estado)
      OCIOSO:  if (iniciar) proximo = CARREGA;
      CARREGA: begin
        limpa   = 1'b1;
        proximo = ACESO;
      end
      ACESO: begin
        limite = nivel_reg ? LIM_RAPIDO : LIM_LENTO;
        if (!pausa) begin
          if (fim_tempo) begin
            limpa   = 1'b1;
            proximo = APAGADO;
          end else begin
            conta = 1'b1;
          end
        end
      end
      APAGADO: begin
        limite = LIM_INTERVALO;
        if (!pausa) begin
          if (fim_tempo) begin
            limpa   = 1'b1;
            proximo = (endereco == rodada_reg) ? FIM : PROXIMO;
          end else begin
            conta = 1'b1;
          end
        end
      end
      PROXIMO: proximo = CARREGA;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      rodada_reg <= '0;
      nivel_reg  <= 1'b0;
      exibicao   <= '0;
    end else begin
      case (estado)
        OCIOSO: if (iniciar) begin
          rodada_reg <= rodada;
          nivel_reg  <= nivel_tempo;
          endereco   <= '0;
        end
        CARREGA: exibicao <= dado_mem;
        PROXIMO: endereco <= endereco + 4'd1;
        default: ;
      endcase
    end
  end

  assign leds      = (estado == ACESO) ? exibicao : '0;
  assign toca      = |leds;
  assign ocupado   = (estado != OCIOSO);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule
